// File: rtl/hash_table_arbiter.sv
// hash_table_arbiter
//   Shares one hash_table insert/lookup/erase engine among NUM_REQ requesters.
//   Round-robin grant, one operation in flight; key/value/strobes are held for
//   the table's IDLE->SEARCH->DONE walk and the result is returned as a
//   one-cycle pulse to the requester that was granted.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   per-requester request / one-hot accept pulse
//   req_op/key/value      per-requester packed op (01 ins, 10 lkp, 11 ers), key, value
//   rsp_valid             one-hot response pulse (no backpressure)
//   rsp_success/value     result from the table
//   rsp_timeout           watchdog abort flag
//   ht_*                  hash_table key/value/strobes out; success/value_out/state in
//
// Build option
//   HT_ARB_TIMEOUT_EN     enables the WAIT-state watchdog (TIMEOUT_CYCLES);
//                         otherwise WAIT waits indefinitely and rsp_timeout is 0.
module hash_table_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int KEY_WIDTH      = 32,
  parameter int VALUE_WIDTH    = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [2*NUM_REQ-1:0]           req_op,
  input  logic [KEY_WIDTH*NUM_REQ-1:0]   req_key,
  input  logic [VALUE_WIDTH*NUM_REQ-1:0] req_value,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic                           rsp_success,
  output logic [VALUE_WIDTH-1:0]         rsp_value,
  output logic                           rsp_timeout,
  output logic [KEY_WIDTH-1:0]           ht_key,
  output logic [VALUE_WIDTH-1:0]         ht_value,
  output logic                           ht_insert,
  output logic                           ht_lookup,
  output logic                           ht_erase,
  input  logic                           ht_success,
  input  logic [VALUE_WIDTH-1:0]         ht_value_out,
  input  logic [1:0]                     ht_state
);

  localparam int          PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NREQ_U = NUM_REQ;

  localparam logic [1:0] HT_IDLE   = 2'd0;
  localparam logic [1:0] HT_DONE   = 2'd2;
  localparam logic [1:0] OP_RSVD   = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_LOOKUP = 2'b10;
  localparam logic [1:0] OP_ERASE  = 2'b11;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_t;

  arb_state_t             state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [PTR_W-1:0]       gnt_q, gnt_d;
  logic [1:0]             op_q, op_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic [VALUE_WIDTH-1:0] value_q, value_d;
  logic                   success_q, success_d;
  logic [VALUE_WIDTH-1:0] rvalue_q, rvalue_d;
`ifdef HT_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic                   timeout_q, timeout_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
`endif

  // First valid requester strictly after the pointer, wrapping around.
  logic             found;
  logic [PTR_W-1:0] pick;

  always_comb begin : rr_pick
    logic [PTR_W-1:0] cand;
    cand  = '0;
    found = 1'b0;
    pick  = ptr_q;
    for (int unsigned i = 1; i <= NREQ_U; i++) begin
      cand = PTR_W'((32'(ptr_q) + i) % NREQ_U);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    op_d      = op_q;
    key_d     = key_q;
    value_d   = value_q;
    success_d = success_q;
    rvalue_d  = rvalue_q;
`ifdef HT_ARB_TIMEOUT_EN
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
`endif
    req_ready   = '0;
    rsp_valid   = '0;
    rsp_success = 1'b0;
    rsp_value   = '0;
    ht_key      = '0;
    ht_value    = '0;
    ht_insert   = 1'b0;
    ht_lookup   = 1'b0;
    ht_erase    = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        // rst_n gate keeps req_ready low while reset is held with requests pending.
        // Waiting for HT_IDLE also covers a table still walking after a watchdog abort.
        if (rst_n && found && ht_state == HT_IDLE) begin
          req_ready[pick] = 1'b1;
          gnt_d   = pick;
          ptr_d   = pick;
          op_d    = req_op[2*pick +: 2];
          key_d   = req_key[KEY_WIDTH*pick +: KEY_WIDTH];
          value_d = req_value[VALUE_WIDTH*pick +: VALUE_WIDTH];
          if (req_op[2*pick +: 2] == OP_RSVD) begin
            success_d = 1'b0;
            rvalue_d  = '0;
`ifdef HT_ARB_TIMEOUT_EN
            timeout_d = 1'b0;
`endif
            state_d   = ARB_RESP;
          end else begin
            state_d = ARB_ISSUE;
          end
        end
      end
      ARB_ISSUE: begin
        ht_key    = key_q;
        ht_value  = value_q;
        ht_insert = (op_q == OP_INSERT);
        ht_lookup = (op_q == OP_LOOKUP);
        ht_erase  = (op_q == OP_ERASE);
`ifdef HT_ARB_TIMEOUT_EN
        cnt_d     = '0;
`endif
        state_d   = ARB_WAIT;
      end
      ARB_WAIT: begin
        ht_key   = key_q;
        ht_value = value_q;
        // Erase stays asserted: the table's SEARCH walk samples it.
        ht_erase = (op_q == OP_ERASE);
        if (ht_state == HT_DONE) begin
          success_d = ht_success;
          rvalue_d  = ht_value_out;
`ifdef HT_ARB_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          state_d   = ARB_RESP;
        end
`ifdef HT_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          success_d = 1'b0;
          rvalue_d  = '0;
          timeout_d = 1'b1;
          state_d   = ARB_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ARB_RESP: begin
        rsp_valid[gnt_q] = 1'b1;
        rsp_success      = success_q;
        rsp_value        = rvalue_q;
        state_d          = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

`ifdef HT_ARB_TIMEOUT_EN
  assign rsp_timeout = (state_q == ARB_RESP) && timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= PTR_W'(NUM_REQ - 1);
      gnt_q     <= '0;
      op_q      <= '0;
      key_q     <= '0;
      value_q   <= '0;
      success_q <= 1'b0;
      rvalue_q  <= '0;
`ifdef HT_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      op_q      <= op_d;
      key_q     <= key_d;
      value_q   <= value_d;
      success_q <= success_d;
      rvalue_q  <= rvalue_d;
`ifdef HT_ARB_TIMEOUT_EN
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

endmodule
